// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the ROM address from fetch_pc, captures
// {pc, instr} pairs into a small prefetch queue and presents them to decode
// over valid/ready. Redirects flush the queue; out-of-range fetches halt in FAULT.
module instr_fetch_ctrl #(
    parameter int unsigned DEPTH_WORDS = 100,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        fetch_pc;
    entry_t             queue [QDEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               addr_ok;
    logic               pop;
    logic               room;
    logic               push;
    entry_t             head;

    // Fetch address is word-aligned and inside the populated part of the ROM
    assign addr_ok = (fetch_pc[1:0] == 2'b00) &&
                     ({2'b00, fetch_pc[31:2]} < 32'(DEPTH_WORDS));

    // Handshake and space: a same-cycle pop frees a slot for the incoming word
    assign pop  = out_valid && out_ready;
    assign room = (count < CNT_W'(QDEPTH)) || pop;

    // Outputs come from registered state only
    assign imem_addr = fetch_pc;
    assign head      = queue[rd_ptr];
    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: redirect always returns to RUN, bad fetch attempt faults
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = S_RUN;
        end else if ((state == S_RUN) && fetch_en && !addr_ok) begin
            state_next = S_FAULT;
        end
    end

    // FSM outputs: push qualification and sticky fault flag
    always_comb begin
        push  = 1'b0;
        fault = 1'b0;
        case (state)
            S_RUN:   push  = fetch_en && !redirect_valid && addr_ok && room;
            S_FAULT: fault = 1'b1;
            default: begin
                push  = 1'b0;
                fault = 1'b0;
            end
        endcase
    end

    // Fetch PC, pointers and occupancy; redirect flushes and voids any pop
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            queue[wr_ptr] <= '{pc: fetch_pc, instr: imem_rd};
        end
    end

    // Occupancy never exceeds the queue depth
    assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(QDEPTH));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: one instance from PC 0, one from the ROM end.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] imem_addr0, imem_rd0, out_instr0, out_pc0;
    logic        out_valid0, fault0;
    logic [31:0] imem_addr1, imem_rd1, out_instr1, out_pc1;
    logic        out_valid1, fault1;

    int checks;
    int passes;

    // ROM model: word k holds 0x1000_0000 + k
    assign imem_rd0 = 32'h1000_0000 + {2'b00, imem_addr0[31:2]};
    assign imem_rd1 = 32'h1000_0000 + {2'b00, imem_addr1[31:2]};

    instr_fetch_ctrl #(.DEPTH_WORDS(100), .RESET_PC(32'h0000_0000), .QDEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr0), .imem_rd(imem_rd0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid0),
        .out_ready(out_ready), .out_instr(out_instr0), .out_pc(out_pc0), .fault(fault0)
    );

    instr_fetch_ctrl #(.DEPTH_WORDS(100), .RESET_PC(32'h0000_0184), .QDEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr1), .imem_rd(imem_rd1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid1),
        .out_ready(out_ready), .out_instr(out_instr1), .out_pc(out_pc1), .fault(fault1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid0); else passes++;
        checks++; if (fault0 !== 1'b0) $display("FAIL reset_fault got %b want 0", fault0); else passes++;
        checks++; if (imem_addr0 !== 32'h0) $display("FAIL reset_addr0 got %h want 00000000", imem_addr0); else passes++;
        checks++; if (imem_addr1 !== 32'h184) $display("FAIL reset_addr1 got %h want 00000184", imem_addr1); else passes++;
    endtask

    task automatic test_streaming();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL stream_c1_valid got %b want 0", out_valid0); else passes++;
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_valid0 !== 1'b1) $display("FAIL stream_valid k=%0d got %b want 1", k, out_valid0); else passes++;
            checks++; if (out_pc0 !== 32'(4 * k)) $display("FAIL stream_pc k=%0d got %h want %h", k, out_pc0, 32'(4 * k)); else passes++;
            checks++; if (out_instr0 !== 32'h1000_0000 + 32'(k)) $display("FAIL stream_instr k=%0d got %h want %h", k, out_instr0, 32'h1000_0000 + 32'(k)); else passes++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (dut0.count !== 3'd4) $display("FAIL bp_count got %0d want 4", dut0.count); else passes++;
        checks++; if (imem_addr0 !== 32'h10) $display("FAIL bp_addr got %h want 00000010", imem_addr0); else passes++;
        checks++; if (out_pc0 !== 32'h0) $display("FAIL bp_head got %h want 00000000", out_pc0); else passes++;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'(4 * k))
                $display("FAIL bp_drain k=%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid0, out_pc0, 32'(4 * k));
            else passes++;
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL redir_flush got %b want 0", out_valid0); else passes++;
        checks++; if (imem_addr0 !== 32'h40) $display("FAIL redir_addr got %h want 00000040", imem_addr0); else passes++;
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h40) $display("FAIL redir_pc got v=%b pc=%h want v=1 pc=00000040", out_valid0, out_pc0); else passes++;
        checks++; if (out_instr0 !== 32'h1000_0010) $display("FAIL redir_instr got %h want 10000010", out_instr0); else passes++;
        tick();
        checks++; if (out_pc0 !== 32'h44) $display("FAIL redir_next got %h want 00000044", out_pc0); else passes++;
    endtask

    task automatic test_fetch_en();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        fetch_en = 1'b0; out_ready = 1'b1;
        checks++; if (out_pc0 !== 32'h0) $display("FAIL fen_head0 got %h want 00000000", out_pc0); else passes++;
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h4) $display("FAIL fen_head1 got v=%b pc=%h want v=1 pc=00000004", out_valid0, out_pc0); else passes++;
        tick();
        checks++; if (out_valid0 !== 1'b0) $display("FAIL fen_empty got %b want 0", out_valid0); else passes++;
        checks++; if (imem_addr0 !== 32'h8) $display("FAIL fen_addr got %h want 00000008", imem_addr0); else passes++;
    endtask

    task automatic test_end_of_rom();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h184 + 32'(4 * k))
                $display("FAIL eor_pc k=%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid1, out_pc1, 32'h184 + 32'(4 * k));
            else passes++;
            checks++; if (out_instr1 !== 32'h1000_0061 + 32'(k)) $display("FAIL eor_instr k=%0d got %h want %h", k, out_instr1, 32'h1000_0061 + 32'(k)); else passes++;
            checks++; if (fault1 !== 1'b0) $display("FAIL eor_early_fault k=%0d got %b want 0", k, fault1); else passes++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (fault1 !== 1'b1) $display("FAIL eor_fault i=%0d got %b want 1", i, fault1); else passes++;
            checks++; if (out_valid1 !== 1'b0) $display("FAIL eor_valid i=%0d got %b want 0", i, out_valid1); else passes++;
            checks++; if (imem_addr1 !== 32'h190) $display("FAIL eor_addr i=%0d got %h want 00000190", i, imem_addr1); else passes++;
            tick();
        end
    endtask

    task automatic test_fault_recovery();
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault1 !== 1'b0) $display("FAIL rec_fault got %b want 0", fault1); else passes++;
        checks++; if (imem_addr1 !== 32'h8) $display("FAIL rec_addr got %h want 00000008", imem_addr1); else passes++;
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h8) $display("FAIL rec_pc got v=%b pc=%h want v=1 pc=00000008", out_valid1, out_pc1); else passes++;
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault1 !== 1'b0 || out_valid1 !== 1'b0) $display("FAIL mis_redir got f=%b v=%b want f=0 v=0", fault1, out_valid1); else passes++;
        tick();
        checks++; if (fault1 !== 1'b1) $display("FAIL mis_fault got %b want 1", fault1); else passes++;
        checks++; if (out_valid1 !== 1'b0 || imem_addr1 !== 32'h6) $display("FAIL mis_nopush got v=%b addr=%h want v=0 addr=00000006", out_valid1, imem_addr1); else passes++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (dut0.count !== 3'd3) $display("FAIL mid_count got %0d want 3", dut0.count); else passes++;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid0); else passes++;
        checks++; if (fault0 !== 1'b0) $display("FAIL mid_fault got %b want 0", fault0); else passes++;
        checks++; if (imem_addr0 !== 32'h0) $display("FAIL mid_addr got %h want 00000000", imem_addr0); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_fetch_en();
        test_end_of_rom();
        test_fault_recovery();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller sitting between the PC logic and the combinational instruction ROM. Each cycle it drives a word-aligned byte address to the ROM and captures the returned word with its PC into a small prefetch queue. It hands {pc, instruction} pairs to decode over a valid/ready handshake, and handles branch/jump redirects by flushing the queue. It also detects fetches outside the ROM's populated range.

## Interface
- `DEPTH_WORDS`, 100, number of valid 32-bit words in the instruction ROM (word index `addr>>2`)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `QDEPTH`, 4, prefetch queue entries; must be a power of two, ≥2
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `fetch_en`  in  1  fetching permitted this cycle; queue still drains when low
- `imem_addr`  out  32  byte address to instruction ROM; equals `fetch_pc` combinationally
- `imem_rd`  in  32  ROM read data for `imem_addr`, same cycle (combinational ROM)
- `redirect_valid`  in  1  branch/jump taken; load new PC and flush
- `redirect_pc`  in  32  target byte address for redirect
- `out_valid`  out  1  queue head holds a valid entry
- `out_ready`  in  1  decode accepts head this cycle
- `out_instr`  out  32  instruction at queue head
- `out_pc`  out  32  byte PC of `out_instr`
- `fault`  out  1  fetch halted on bad address; sticky until redirect or reset

## Operation
- State: `fetch_pc` (32b), queue storage `QDEPTH`×64b, `rd_ptr`/`wr_ptr` (log2 QDEPTH bits, wrap naturally), `count` (log2 QDEPTH + 1 bits), FSM {RUN, FAULT}.
- Pop: `out_valid && out_ready` → `rd_ptr`+1, `count`−1.
- Push condition (RUN only): `fetch_en && !redirect_valid && addr_ok && (count < QDEPTH || pop)`. `addr_ok` = `fetch_pc[1:0]==0 && (fetch_pc>>2) < DEPTH_WORDS`.
- Push: write {`fetch_pc`, `imem_rd`} at `wr_ptr`; `wr_ptr`+1; `count`+1; `fetch_pc` += 4.
- Simultaneous push+pop: `count` unchanged; allowed when full.
- RUN→FAULT: `fetch_en && !redirect_valid && !addr_ok`. No push; `fetch_pc` holds; `fault`=1 from next cycle. Queued entries continue to drain.
- FAULT: no pushes regardless of `fetch_en`; `fault`=1.
- Redirect (highest priority, either state): `count`←0, `rd_ptr`=`wr_ptr`←0, `fetch_pc`←`redirect_pc`, state←RUN, `fault`←0. Any same-cycle pop handshake is void: the head is discarded, not consumed. No push in the redirect cycle.
- A misaligned or out-of-range `redirect_pc` is accepted. FAULT is entered on the following fetch attempt.
- `fetch_pc` arithmetic is modulo 2^32. Wrap is unreachable in practice because the range check fires first.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, `count`=0, pointers=0, state RUN. Outputs: `out_valid`=0, `fault`=0, `imem_addr`=`RESET_PC`; `out_instr`/`out_pc` are don't-care while `out_valid`=0.
- `imem_addr` is combinational from registered `fetch_pc`; no ROM latency is assumed.
- Fetch-to-decode latency: a word pushed in cycle N is presented with `out_valid`=1 in cycle N+1 at the earliest.
- Throughput: 1 instruction/cycle sustained with `out_ready`=1.
- `out_valid`, `out_instr`, `out_pc` depend only on registered state. There is no combinational path from `out_ready` or `redirect_*` to outputs.
- Redirect in cycle N: the target word is fetched in cycle N+1 and appears at the output in N+2.
- `rst` overrides everything, including a concurrent redirect, and takes effect mid-stream on the next edge.

## Test plan
- Streaming: reset, `fetch_en`=1, `out_ready`=1, ROM word k = 0x1000_0000+k. Required: `out_valid` rises cycle 2; `out_pc` 0,4,8,… one per cycle; `out_instr` matches.
- Backpressure: `out_ready`=0 for 10 cycles. Required: `count` saturates at 4; `imem_addr` holds at 0x10. Then release: PCs 0x0..0xC drain in order with no gap or duplicate.
- Redirect with full queue and `out_ready`=1 in the same cycle: `redirect_pc`=0x40. Required: next cycle `out_valid`=0. The cycle after, `out_pc`=0x40 and `out_instr`=word 16. No stale PC ever appears.
- End of ROM: `RESET_PC`=0x184 (word 97), DEPTH_WORDS=100. Required: PCs 0x184, 0x188, 0x18C are delivered, then `fault`=1 and `imem_addr` stays 0x190. The queue drains, and `out_valid` stays 0 afterwards.
- Fault recovery: in FAULT, redirect to 0x8. Required: `fault`=0 next cycle, then `out_pc`=0x8. Redirect to 0x6 instead: `fault`=1 after the next fetch attempt, with nothing pushed.
- Reset mid-stream: assert `rst` for 1 cycle with queue at 3 entries. Required: next cycle `out_valid`=0, `fault`=0, `imem_addr`=`RESET_PC`.
